// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Holds the sequencer state, funct3 width codes and the legality check.
package lsu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      WB,
      ERR
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Reserved width codes, unsigned stores and misaligned halfwords/words
   function automatic logic is_illegal(
      input logic       st,
      input logic [2:0] f3,
      input logic [1:0] a
   );
      return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111)
          || (st && f3[2])
          || ((f3[1:0] == 2'b01) && a[0])
          || ((f3[1:0] == 2'b10) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword of a read word and extends it
// according to the load funct3.
module load_extend
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] rdata_i,
   input  logic [1:0]      addr_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b = rdata_i[{addr_i, 3'b000} +: 8];
      h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{b[7]}}, b};
         F3_BU:   data_o = {24'b0, b};
         F3_H:    data_o = {{16{h[15]}}, h};
         F3_HU:   data_o = {16'b0, h};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Sequences one RV32I load or store against a handshaked data memory
// and drives the register-file write port with the extended load data.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [4:0]      req_rd,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_wmask,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            rf_we,
   output logic [4:0]      rf_a3,
   output logic [XLEN-1:0] rf_wd3,
   output logic            done,
   output logic            err
);

   state_e            state_q, state_d;
   logic              store_q;
   logic [2:0]        f3_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   ext_q;
   logic [XLEN-1:0]   ext;
   logic [3:0]        mask;
   logic [XLEN-1:0]   wrep;

   load_extend u_ext (
      .rdata_i  (mem_rdata),
      .addr_i   (addr_q[1:0]),
      .funct3_i (f3_q),
      .data_o   (ext)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         store_q <= 1'b0;
         f3_q    <= 3'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 5'b0;
         ext_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && req_valid) begin
            store_q <= req_store;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
         end
         if (state_q == WAIT && mem_rvalid)
            ext_q <= ext;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:
            if (req_valid)
               state_d = is_illegal(req_store, req_funct3, req_addr[1:0])
                       ? ERR : REQ;
         REQ:
            if (mem_gnt)
               state_d = store_q ? IDLE : WAIT;
         WAIT:
            if (mem_rvalid)
               state_d = WB;
         WB:      state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Lane mask and replicated data come from captured fields only
   always_comb begin
      case (f3_q[1:0])
         2'b00: begin
            mask = 4'b0001 << addr_q[1:0];
            wrep = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            mask = addr_q[1] ? 4'b1100 : 4'b0011;
            wrep = {2{wdata_q[15:0]}};
         end
         default: begin
            mask = 4'b1111;
            wrep = wdata_q;
         end
      endcase
   end

   assign req_ready = (state_q == IDLE);
   assign mem_req   = (state_q == REQ);
   assign mem_we    = mem_req && store_q;
   assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
   assign mem_wmask = mem_we ? mask : 4'b0;
   assign mem_wdata = mem_we ? wrep : '0;
   assign rf_we     = (state_q == WB) && (rd_q != 5'd0);
   assign rf_a3     = (state_q == WB) ? rd_q : 5'd0;
   assign rf_wd3    = (state_q == WB) ? ext_q : '0;
   assign err       = (state_q == ERR);
   assign done      = (mem_we && mem_gnt) || (state_q == WB) || err;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit with a byte-level
// reference model and a latency-randomizing memory responder.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic        rf_we, done, err;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd3;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
      .done(done), .err(err)
   );

   typedef struct {
      bit        err;
      bit        store;
      bit        we;
      bit [4:0]  rd;
      bit [31:0] wd;
   } done_t;

   typedef struct {
      bit [31:0] addr;
      bit        we;
      bit [3:0]  mask;
      bit [31:0] wdata;
   } memx_t;

   done_t     exp_q[$];
   memx_t     mexp_q[$];
   int        acc_q[$];
   int        n_cmp = 0;
   int        n_bad = 0;
   int        cyc = 0;
   int        last_rv = -10;
   int        gnt_fix = -1;
   int        rv_fix = -1;
   bit [31:0] mem_init[bit [31:0]];

   function automatic bit [31:0] memword(bit [31:0] a);
      if (mem_init.exists(a)) return mem_init[a];
      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, expv, cyc);
      end
   endtask

   // Reference model: expected memory beat and completion per request
   task automatic issue(bit st, bit [2:0] f3, bit [31:0] a,
                        bit [31:0] wd, bit [4:0] rd, bit nodone = 0);
      int        n;
      int        off;
      bit        legal;
      bit        ok;
      done_t     e;
      memx_t     m;
      bit [31:0] w, v, msk;
      n     = 1 << f3[1:0];
      off   = int'(a % 4);
      legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7)
           && !(st && f3[2]) && ((a % n) == 0);
      e.err = !legal; e.store = st; e.rd = rd; e.we = 0; e.wd = 0;
      if (legal) begin
         m.addr = a & ~32'h3; m.we = st; m.mask = 0; m.wdata = 0;
         if (st) begin
            for (int i = 0; i < 4; i++) begin
               if (i >= off && i < off + n) m.mask[i] = 1'b1;
               m.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
            end
         end else begin
            w = memword(m.addr) >> (8 * off);
            if (n == 4) v = w;
            else begin
               msk = (32'h1 << (8 * n)) - 1;
               v = w & msk;
               if (!f3[2] && v[8*n-1]) v = v | ~msk;
            end
            e.we = (rd != 0);
            e.wd = v;
         end
         mexp_q.push_back(m);
      end
      if (!nodone) exp_q.push_back(e);
      req_valid = 1; req_store = st; req_funct3 = f3;
      req_addr = a; req_wdata = wd; req_rd = rd;
      ok = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (req_ready) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      req_valid = 0;
   endtask

   task automatic drain();
      int k;
      for (k = 0; k < 500; k++) begin
         if (exp_q.size() == 0 && mexp_q.size() == 0) break;
         @(posedge clk); #1;
      end
      if (k == 500) chk("drain_timeout", exp_q.size(), 32'd0);
   endtask

   task automatic chk_reset_vals();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_wmask", mem_wmask, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_a3", rf_a3, 0);
      chk("rst_rf_wd3", rf_wd3, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
   endtask

   // Memory responder: random grant delay, read latency of 1..3 cycles
   initial begin
      int        gd, rdl;
      bit        pend, armed;
      bit [31:0] rw;
      gd = 0; rdl = 0; pend = 0; armed = 0; rw = 0;
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      forever begin
         @(posedge clk); #1;
         mem_gnt = 0; mem_rvalid = 0;
         if (reset) armed = 0;
         if (pend) begin
            if (rdl == 0) begin
               mem_rvalid = 1; mem_rdata = rw; pend = 0;
            end else rdl--;
         end else if (mem_req && !reset) begin
            if (!armed) begin
               armed = 1;
               gd = (gnt_fix >= 0) ? gnt_fix : int'($urandom_range(3));
            end
            if (gd == 0) begin
               mem_gnt = 1; armed = 0;
               if (!mem_we) begin
                  pend = 1;
                  rdl = (rv_fix >= 0) ? rv_fix : int'($urandom_range(2));
                  rw = memword(mem_addr);
               end
            end else gd--;
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT signals an event
   initial begin
      done_t e;
      memx_t m;
      int    acc;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) acc_q.delete();
         else begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (mem_req && mem_gnt) begin
               if (mexp_q.size() == 0) chk("unexpected_mem", 1, 0);
               else begin
                  m = mexp_q.pop_front();
                  chk("mem_addr", mem_addr, m.addr);
                  chk("mem_we", mem_we, m.we);
                  if (m.we) begin
                     chk("mem_wmask", mem_wmask, m.mask);
                     chk("mem_wdata", mem_wdata, m.wdata);
                  end
               end
            end
            if (rf_we && !done) chk("rf_we_without_done", rf_we, 0);
            if (done) begin
               if (exp_q.size() == 0 || acc_q.size() == 0)
                  chk("unexpected_done", done, 0);
               else begin
                  e = exp_q.pop_front();
                  acc = acc_q.pop_front();
                  chk("err", err, e.err);
                  chk("rf_we", rf_we, e.we);
                  if (e.err) chk("err_latency", cyc - acc, 1);
                  else if (e.store) chk("store_done_in_gnt", mem_gnt, 1);
                  else begin
                     chk("load_wb_latency", cyc - last_rv, 1);
                     if (e.we) begin
                        chk("rf_a3", rf_a3, e.rd);
                        chk("rf_wd3", rf_wd3, e.wd);
                     end
                  end
               end
            end
            if (mem_rvalid) last_rv = cyc;
         end
      end
   end

   initial begin
      bit        st;
      bit [2:0]  f3;
      bit [31:0] a;
      int        cnt;
      bit        seen;
      reset = 1; req_valid = 0; req_store = 0; req_funct3 = 0;
      req_addr = 0; req_wdata = 0; req_rd = 0;
      repeat (2) @(negedge clk);
      chk_reset_vals();
      @(posedge clk); #1;
      reset = 0;

      mem_init[32'h100] = 32'h12803456;
      gnt_fix = 2;
      issue(1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0);
      gnt_fix = -1;
      issue(1, 3'b000, 32'h103, 32'h000000A5, 5'd0);
      issue(0, 3'b000, 32'h102, 32'h0, 5'd5);
      issue(0, 3'b100, 32'h102, 32'h0, 5'd6);
      issue(0, 3'b001, 32'h101, 32'h0, 5'd7);
      issue(0, 3'b011, 32'h100, 32'h0, 5'd7);
      issue(0, 3'b010, 32'h100, 32'h0, 5'd0);
      issue(1, 3'b001, 32'h106, 32'h0000BEEF, 5'd0);
      issue(1, 3'b100, 32'h104, 32'h1, 5'd0);
      drain();

      rv_fix = 3;
      issue(0, 3'b010, 32'h200, 32'h0, 5'd9, 1);
      seen = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (mem_gnt) begin seen = 1; break; end
      end
      chk("reset_test_gnt_seen", seen, 1);
      @(posedge clk); #1;
      reset = 1;
      @(negedge clk);
      chk_reset_vals();
      @(posedge clk); #1;
      reset = 0;
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done || rf_we) cnt++;
      end
      chk("stale_rvalid_ignored", cnt, 0);
      rv_fix = -1;
      @(posedge clk); #1;
      issue(0, 3'b001, 32'h302, 32'h0, 5'd3);
      drain();

      for (int t = 0; t < 300; t++) begin
         st = ($urandom % 3) == 0;
         if ($urandom % 8 == 0) f3 = 3'($urandom);
         else if (st) f3 = 3'($urandom % 3);
         else begin
            case ($urandom % 5)
               0: f3 = 3'b000;
               1: f3 = 3'b001;
               2: f3 = 3'b010;
               3: f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
         end
         a = 32'h1000 + ($urandom & 32'hFF);
         if ($urandom % 3 == 0) a = a & ~32'h3;
         issue(st, f3, a, $urandom, 5'($urandom));
         if ($urandom % 4 == 0)
            repeat ($urandom_range(3)) begin @(posedge clk); #1; end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
